// File: rtl/pc_gen_pipe_if.sv
// -----------------------------------------------------------------------------
// pc_gen_pipe_if
//   Bundles the redirect inputs and the fetch request/status outputs of the
//   program-counter generator.
//
//   master : the PC generator (drives fetch_* and misalign*, samples the rest)
//   slave  : the consumer side (redirect sources, halt control, fetch stage)
//
//   Signals:
//     redir_en    [NREDIR]       per-source redirect request, index 0 highest priority
//     redir_pc    [NREDIR*XLEN]  per-source target, source i at [i*XLEN +: XLEN]
//     halt                       level request to stop issuing fetches
//     fetch_valid                fetch_pc/fetch_epoch form a valid request
//     fetch_ready                fetch stage accepts the request
//     fetch_pc    [XLEN]         current fetch address
//     fetch_epoch [EPOCH_W]      epoch tag attached to the request
//     misalign                   one-cycle pulse: selected redirect target misaligned
//     misalign_pc [XLEN]         offending target, held until the next misalign
//
//   Handshake: a request transfers on a rising clk edge where fetch_valid and
//   fetch_ready are both high. While valid is high and ready is low, fetch_pc
//   and fetch_epoch stay stable EXCEPT when an aligned redirect arrives; the
//   redirect replaces the request and bumps the epoch, and the consumer drops
//   anything tagged with a stale epoch.
// -----------------------------------------------------------------------------
interface pc_gen_pipe_if #(
  parameter int XLEN    = 64,
  parameter int NREDIR  = 3,
  parameter int EPOCH_W = 2
) ();

  logic [NREDIR-1:0]      redir_en;
  logic [NREDIR*XLEN-1:0] redir_pc;
  logic                   halt;
  logic                   fetch_valid;
  logic                   fetch_ready;
  logic [XLEN-1:0]        fetch_pc;
  logic [EPOCH_W-1:0]     fetch_epoch;
  logic                   misalign;
  logic [XLEN-1:0]        misalign_pc;

  modport master (
    input  redir_en,
    input  redir_pc,
    input  halt,
    input  fetch_ready,
    output fetch_valid,
    output fetch_pc,
    output fetch_epoch,
    output misalign,
    output misalign_pc
  );

  modport slave (
    output redir_en,
    output redir_pc,
    output halt,
    output fetch_ready,
    input  fetch_valid,
    input  fetch_pc,
    input  fetch_epoch,
    input  misalign,
    input  misalign_pc
  );

endinterface

// File: rtl/pc_gen_pipe.sv
// -----------------------------------------------------------------------------
// pc_gen_pipe
//   Program-counter generator in front of the instruction-fetch stage.
//   Issues sequential fetch requests over a valid/ready handshake, accepts
//   NREDIR prioritised redirects (trap unit, EX branch, ID jump), tags every
//   request with an epoch that changes on each taken redirect, and provides
//   halt and fault (misaligned redirect target) states.
//
//   Ports:
//     clk        clock, all state updates on the rising edge
//     rstn       synchronous active-low reset
//     bus        pc_gen_pipe_if.master (redirects, halt, fetch handshake,
//                misalign report)
//     state_dbg  current FSM state (BOOT=0, RUN=1, HALT=2, FAULT=3)
// -----------------------------------------------------------------------------
module pc_gen_pipe #(
  parameter int          XLEN    = 64,
  parameter logic [63:0] RST_VEC = 64'h8000_0000,
  parameter int          NREDIR  = 3,
  parameter int          STEP    = 4,
  parameter int          EPOCH_W = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  pc_gen_pipe_if.master        bus,
  output logic [1:0]           state_dbg
);

  // FSM encoding
  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  localparam logic [XLEN-1:0] RST_PC     = RST_VEC[XLEN-1:0];
  localparam logic [XLEN-1:0] STEP_PC    = XLEN'(STEP);
  // STEP is a power of two, so alignment is a check of the low bits.
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);

  // Registered state
  logic [1:0]         state_q;
  logic [XLEN-1:0]    pc_q;
  logic [EPOCH_W-1:0] epoch_q;
  logic               mis_q;
  logic [XLEN-1:0]    mis_pc_q;

  // Next-state values
  logic [1:0]         state_d;
  logic [XLEN-1:0]    pc_d;
  logic [EPOCH_W-1:0] epoch_d;
  logic               mis_d;
  logic [XLEN-1:0]    mis_pc_d;

  // Redirect selection
  logic               redir_any;
  logic [XLEN-1:0]    sel_pc;
  logic               sel_aligned;

  // ---------------------------------------------------------------------------
  // Priority encoder: scanning from the highest index down lets the lowest
  // requesting index overwrite last, so source 0 wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    redir_any = 1'b0;
    sel_pc    = '0;
    for (int i = NREDIR - 1; i >= 0; i--) begin
      if (bus.redir_en[i]) begin
        redir_any = 1'b1;
        sel_pc    = bus.redir_pc[i*XLEN +: XLEN];
      end
    end
  end

  assign sel_aligned = ((sel_pc & ALIGN_MASK) == '0);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    epoch_d  = epoch_q;
    mis_d    = 1'b0;       // misalign is a single-cycle pulse
    mis_pc_d = mis_pc_q;   // offending target sticks until the next one

    if (state_q == BOOT) begin
      // Redirects are ignored while booting; the first request is RST_PC.
      state_d = bus.halt ? HALT : RUN;
    end else if (redir_any) begin
      // A redirect outranks both the handshake and halt. Only the selected
      // source is considered, so a misaligned winner masks any lower-priority
      // aligned request.
      if (sel_aligned) begin
        pc_d    = sel_pc;
        epoch_d = epoch_q + EPOCH_W'(1);
        if (state_q == FAULT) begin
          state_d = RUN;
        end
      end else begin
        mis_d    = 1'b1;
        mis_pc_d = sel_pc;
        state_d  = FAULT;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          // valid is always high in RUN, so an accept is just fetch_ready.
          // Halt is taken only once nothing is left pending; if the request
          // is accepted on the same edge, the advance still happens.
          if (bus.fetch_ready) begin
            pc_d = pc_q + STEP_PC;
            if (bus.halt) begin
              state_d = HALT;
            end
          end
        end
        HALT: begin
          // Resume with the held PC as the first request.
          if (!bus.halt) begin
            state_d = RUN;
          end
        end
        FAULT: begin
          // Only an aligned redirect leaves FAULT.
          state_d = FAULT;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers (synchronous active-low reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= BOOT;
      pc_q     <= RST_PC;
      epoch_q  <= '0;
      mis_q    <= 1'b0;
      mis_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      epoch_q  <= epoch_d;
      mis_q    <= mis_d;
      mis_pc_q <= mis_pc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.fetch_valid = (state_q == RUN);
  assign bus.fetch_pc    = pc_q;
  assign bus.fetch_epoch = epoch_q;
  assign bus.misalign    = mis_q;
  assign bus.misalign_pc = mis_pc_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_pc_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_pc_gen_pipe
//   Directed bench for pc_gen_pipe. dut_a is the default XLEN=64 build and is
//   driven from a table of per-cycle {inputs, expected outputs}; dut_b is an
//   XLEN=32 build used for the 32-bit PC wrap. Hand-written sequences cover
//   reset during a stall, BOOT behaviour and the epoch wrap.
// -----------------------------------------------------------------------------
module tb_pc_gen_pipe;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_HALT = 2'd2;

  pc_gen_pipe_if #(.XLEN(64), .NREDIR(3), .EPOCH_W(2)) ifa ();
  pc_gen_pipe_if #(.XLEN(32), .NREDIR(3), .EPOCH_W(2)) ifb ();

  logic [1:0] st_a;
  logic [1:0] st_b;

  pc_gen_pipe #(.XLEN(64), .RST_VEC(64'h8000_0000), .NREDIR(3), .STEP(4), .EPOCH_W(2)) dut_a (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (ifa),
    .state_dbg (st_a)
  );

  pc_gen_pipe #(.XLEN(32), .RST_VEC(64'h8000_0000), .NREDIR(3), .STEP(4), .EPOCH_W(2)) dut_b (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (ifb),
    .state_dbg (st_b)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        rstn;
    logic [2:0]  en;
    logic [63:0] p0;
    logic [63:0] p1;
    logic [63:0] p2;
    logic        halt;
    logic        ready;
    logic        e_valid;
    logic [63:0] e_pc;
    logic [1:0]  e_epoch;
    logic        e_mis;
    logic [63:0] e_mpc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [2:0] en,
                     input logic [63:0] p0, input logic [63:0] p1, input logic [63:0] p2,
                     input logic h, input logic rdy,
                     input logic ev, input logic [63:0] epc, input logic [1:0] eep,
                     input logic emis, input logic [63:0] empc);
    vec_t v;
    v.rstn = r;  v.en = en; v.p0 = p0; v.p1 = p1; v.p2 = p2;
    v.halt = h;  v.ready = rdy;
    v.e_valid = ev; v.e_pc = epc; v.e_epoch = eep; v.e_mis = emis; v.e_mpc = empc;
    vq.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int idx);
    rstn            = v.rstn;
    ifa.redir_en    = v.en;
    ifa.redir_pc    = {v.p2, v.p1, v.p0};
    ifa.halt        = v.halt;
    ifa.fetch_ready = v.ready;
    tick();
    check($sformatf("row%0d valid", idx), 64'(ifa.fetch_valid), 64'(v.e_valid));
    check($sformatf("row%0d pc", idx), ifa.fetch_pc, v.e_pc);
    check($sformatf("row%0d epoch", idx), 64'(ifa.fetch_epoch), 64'(v.e_epoch));
    check($sformatf("row%0d misalign", idx), 64'(ifa.misalign), 64'(v.e_mis));
    check($sformatf("row%0d misalign_pc", idx), ifa.misalign_pc, v.e_mpc);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rstn            = 1'b0;
    ifa.redir_en    = '0;
    ifa.redir_pc    = '0;
    ifa.halt        = 1'b0;
    ifa.fetch_ready = 1'b1;
    ifb.redir_en    = '0;
    ifb.redir_pc    = '0;
    ifb.halt        = 1'b0;
    ifb.fetch_ready = 1'b1;

    //  rstn en    p0          p1          p2     halt rdy | valid pc          ep mis mpc
    add(0, 3'b000, 64'h0,      64'h0,      64'h0,   0, 1,  0, 64'h8000_0000, 0, 0, 64'h0);   // 0 reset
    add(1, 3'b000, 64'h0,      64'h0,      64'h0,   0, 1,  1, 64'h8000_0000, 0, 0, 64'h0);   // 1 BOOT->RUN
    add(1, 3'b000, 64'h0,      64'h0,      64'h0,   0, 1,  1, 64'h8000_0004, 0, 0, 64'h0);
    add(1, 3'b000, 64'h0,      64'h0,      64'h0,   0, 1,  1, 64'h8000_0008, 0, 0, 64'h0);
    add(1, 3'b000, 64'h0,      64'h0,      64'h0,   0, 1,  1, 64'h8000_000C, 0, 0, 64'h0);
    add(1, 3'b000, 64'h0,      64'h0,      64'h0,   0, 1,  1, 64'h8000_0010, 0, 0, 64'h0);   // 5
    add(1, 3'b000, 64'h0,      64'h0,      64'h0,   0, 0,  1, 64'h8000_0010, 0, 0, 64'h0);   // stall x3
    add(1, 3'b000, 64'h0,      64'h0,      64'h0,   0, 0,  1, 64'h8000_0010, 0, 0, 64'h0);
    add(1, 3'b000, 64'h0,      64'h0,      64'h0,   0, 0,  1, 64'h8000_0010, 0, 0, 64'h0);
    add(1, 3'b000, 64'h0,      64'h0,      64'h0,   0, 1,  1, 64'h8000_0014, 0, 0, 64'h0);   // 9
    add(1, 3'b110, 64'h0,      64'h100,    64'h200, 0, 1,  1, 64'h100,       1, 0, 64'h0);   // 10 redirect beats accept
    add(1, 3'b001, 64'h102,    64'h0,      64'h0,   0, 1,  0, 64'h100,       1, 1, 64'h102); // 11 misaligned
    add(1, 3'b000, 64'h0,      64'h0,      64'h0,   0, 1,  0, 64'h100,       1, 0, 64'h102); // 12 FAULT, pulse gone
    add(1, 3'b001, 64'h1000,   64'h0,      64'h0,   0, 1,  1, 64'h1000,      2, 0, 64'h102); // 13 FAULT->RUN
    add(1, 3'b000, 64'h0,      64'h0,      64'h0,   1, 0,  1, 64'h1000,      2, 0, 64'h102); // 14 halt while pending
    add(1, 3'b000, 64'h0,      64'h0,      64'h0,   1, 0,  1, 64'h1000,      2, 0, 64'h102);
    add(1, 3'b000, 64'h0,      64'h0,      64'h0,   1, 1,  0, 64'h1004,      2, 0, 64'h102); // 16 accept + HALT
    add(1, 3'b001, 64'h400,    64'h0,      64'h0,   1, 1,  0, 64'h400,       3, 0, 64'h102); // 17 redirect in HALT
    add(1, 3'b000, 64'h0,      64'h0,      64'h0,   1, 1,  0, 64'h400,       3, 0, 64'h102);
    add(1, 3'b000, 64'h0,      64'h0,      64'h0,   0, 0,  1, 64'h400,       3, 0, 64'h102); // 19 resume
    add(1, 3'b000, 64'h0,      64'h0,      64'h0,   0, 1,  1, 64'h404,       3, 0, 64'h102);
    add(1, 3'b001, 64'h3,      64'h0,      64'h0,   0, 1,  0, 64'h404,       3, 1, 64'h3);   // 21 misaligned
    add(1, 3'b010, 64'h0,      64'h6,      64'h0,   0, 1,  0, 64'h404,       3, 1, 64'h6);   // 22 back-to-back pulse
    add(1, 3'b011, 64'h2000,   64'h7,      64'h0,   0, 1,  1, 64'h2000,      0, 0, 64'h6);   // 23 epoch 3->0
    add(1, 3'b011, 64'h9,      64'h3000,   64'h0,   0, 1,  0, 64'h2000,      0, 1, 64'h9);   // 24 misaligned masks aligned
    add(1, 3'b000, 64'h0,      64'h0,      64'h0,   0, 1,  0, 64'h2000,      0, 0, 64'h9);   // 25

    tick();
    foreach (vq[i]) apply(vq[i], i);

    // Reset in the middle of a stall, with a redirect also requested.
    ifa.redir_en = 3'b001; ifa.redir_pc = {64'h0, 64'h0, 64'h5000}; ifa.fetch_ready = 1'b1;
    tick();
    check("redir 5000 pc", ifa.fetch_pc, 64'h5000);
    check("redir 5000 epoch", 64'(ifa.fetch_epoch), 64'd1);
    ifa.redir_en = 3'b000; ifa.fetch_ready = 1'b0;
    tick();
    check("stall valid", 64'(ifa.fetch_valid), 64'd1);
    rstn = 1'b0; ifa.redir_en = 3'b001; ifa.redir_pc = {64'h0, 64'h0, 64'h40};
    tick();
    check("rst stall pc", ifa.fetch_pc, 64'h8000_0000);
    check("rst stall valid", 64'(ifa.fetch_valid), 64'd0);
    check("rst stall epoch", 64'(ifa.fetch_epoch), 64'd0);
    check("rst stall misalign_pc", ifa.misalign_pc, 64'h0);
    check("rst stall state", 64'(st_a), 64'(ST_BOOT));

    // BOOT ignores redirects and honours halt.
    rstn = 1'b1; ifa.halt = 1'b1;
    tick();
    check("boot redir ignored pc", ifa.fetch_pc, 64'h8000_0000);
    check("boot redir ignored epoch", 64'(ifa.fetch_epoch), 64'd0);
    check("boot halt valid", 64'(ifa.fetch_valid), 64'd0);
    check("boot halt state", 64'(st_a), 64'(ST_HALT));
    ifa.redir_en = 3'b000; ifa.halt = 1'b0;
    tick();
    check("resume valid", 64'(ifa.fetch_valid), 64'd1);
    check("resume pc", ifa.fetch_pc, 64'h8000_0000);

    // Four aligned redirects: epoch 1,2,3,0.
    exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    ifa.fetch_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [63:0] tgt;
      logic [1:0]  e;
      tgt = 64'((k + 1) * 16);
      ifa.redir_en = 3'b001; ifa.redir_pc = {64'h0, 64'h0, tgt};
      tick();
      e = exp_q.pop_front();
      check($sformatf("epoch seq %0d", k), 64'(ifa.fetch_epoch), 64'(e));
      check($sformatf("epoch seq pc %0d", k), ifa.fetch_pc, tgt);
    end
    ifa.redir_en = 3'b000;

    // XLEN=32 wrap on dut_b.
    ifb.redir_en = 3'b001; ifb.redir_pc = {32'h0, 32'h0, 32'hFFFF_FFFC};
    tick();
    check("x32 redir pc", 64'(ifb.fetch_pc), 64'hFFFF_FFFC);
    check("x32 redir valid", 64'(ifb.fetch_valid), 64'd1);
    ifb.redir_en = 3'b000; ifb.fetch_ready = 1'b1;
    tick();
    check("x32 wrap pc", 64'(ifb.fetch_pc), 64'h0);
    check("x32 wrap epoch", 64'(ifb.fetch_epoch), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_gen_pipe.md
Name: pc_gen_pipe

Overview:
Parametrised program-counter generator for the pipelined core. It replaces the single-redirect, always-advancing PC register with four additions: a valid/ready fetch handshake, NREDIR prioritised redirect sources, an epoch tag for squashing stale fetches, and halt/fault states. It sits in front of the instruction-fetch stage. It takes redirect requests from the trap unit, EX branch resolution and ID jump decode.

Parameters:
XLEN, 64, PC width in bits (32 or 64).
RST_VEC, 64'h8000_0000, PC value after reset; truncated to XLEN.
NREDIR, 3, number of redirect sources; index 0 has highest priority.
STEP, 4, sequential PC increment in bytes; power of two, 2 or 4.
EPOCH_W, 2, width of the epoch counter.

Ports:
clk  in  1  clock
rstn  in  1  reset: synchronous, active-low
redir_en  in  NREDIR  per-source redirect request
redir_pc  in  NREDIR*XLEN  per-source target; source i occupies bits [i*XLEN +: XLEN]
halt  in  1  level request to stop issuing fetches
fetch_valid  out  1  fetch_pc is a valid request
fetch_ready  in  1  fetch stage accepts the request
fetch_pc  out  XLEN  current fetch address
fetch_epoch  out  EPOCH_W  epoch tag attached to the current request
misalign  out  1  one-cycle pulse: the selected redirect target is misaligned
misalign_pc  out  XLEN  offending target, held until the next misalign

Behaviour:
- All state updates on posedge clk. rstn low forces:
  - state=BOOT, fetch_pc=RST_VEC, fetch_valid=0, fetch_epoch=0, misalign=0, misalign_pc=0.
  - Reset mid-operation discards any pending request or redirect.
- States:
  - BOOT: valid=0. Next cycle goes to RUN; goes to HALT instead if halt=1.
  - RUN: valid=1.
  - HALT: valid=0.
  - FAULT: valid=0, reached after a misaligned redirect.
- Redirect selection:
  - sel = lowest index i with redir_en[i]=1. Combinational priority encoder; no latency beyond the register.
  - Target aligned means (target mod STEP)==0.
- Aligned redirect, any state except BOOT:
  - fetch_pc <= target; fetch_epoch <= epoch+1, wrapping modulo 2^EPOCH_W.
  - State: FAULT goes to RUN. HALT stays HALT. RUN stays RUN.
  - Overrides the handshake: fetch_pc may change while valid=1 and ready=0. The consumer drops data whose epoch mismatches.
  - In BOOT, redirects are ignored.
- Misaligned redirect:
  - Next cycle: misalign=1, misalign_pc=target.
  - fetch_pc and epoch are unchanged; state goes to FAULT from RUN or HALT.
  - Lower-priority aligned redirects in the same cycle are ignored.
- Sequential advance, RUN with no redirect:
  - valid&&ready gives fetch_pc <= fetch_pc+STEP, modulo 2^XLEN.
  - valid&&!ready holds fetch_pc stable; valid stays high.
- Halt:
  - In RUN with halt=1, state goes to HALT only on a cycle with no pending unaccepted request (valid&&!ready) and no redirect.
  - If the request is accepted that cycle, the PC advance happens and HALT is entered the same edge.
  - HALT goes to RUN when halt=0; the first fetch is the held fetch_pc.
- Simultaneous redirect and accept: the redirect wins. The accepted request is not advanced past; fetch_pc=target.
- misalign is high for exactly one cycle per misaligned redirect. Back-to-back misaligned redirects give consecutive pulses.
- fetch_epoch changes only on an aligned redirect.

Test Plan:
- Reset release, XLEN=64, halt=0, ready=1 -> cycle0 valid=0 pc=0x80000000; cycle1 valid=1; cycles 2..4 pc=0x80000004, 0x80000008, 0x8000000C; epoch=0 throughout.
- ready=0 for 3 cycles at pc=0x80000010 -> pc and valid held; ready=1 -> next pc=0x80000014.
- Same-cycle redir_en=3'b110 (pc1=0x100, pc2=0x200) with an accept -> next pc=0x100, epoch=1; source 2 ignored.
- redir_en[0] with target 0x102, STEP=4 -> misalign pulse of 1 cycle, misalign_pc=0x102, valid=0 (FAULT); then redir_en[0] with 0x1000 -> RUN, pc=0x1000, epoch incremented.
- halt=1 while valid&&!ready -> stays RUN until accepted, then valid=0; redirect to 0x400 while halted -> pc=0x400, still valid=0; halt=0 -> valid=1, pc=0x400.
- Wrap cases:
  - XLEN=32, pc=0xFFFFFFFC, accepted -> pc=0x00000000.
  - 4 consecutive aligned redirects with EPOCH_W=2 -> epoch sequence 1,2,3,0.
  - rstn low mid-stall -> pc=RST_VEC, valid=0, epoch=0.
